// File: rtl/i2s_rx_multi.sv
// Multi-line I2S receiver: captures one MSB-first word per channel per data line and
// delivers each completed left/right frame on a valid/ready port with sync tracking.
module i2s_rx_multi #(
  parameter int unsigned NLINES = 1,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned OFFSET = 1
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     sample,
  input  logic [5:0]               frame_posn,
  input  logic [NLINES-1:0]        sd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLINES*WIDTH-1:0]  left,
  output logic [NLINES*WIDTH-1:0]  right,
  output logic                     locked,
  output logic                     sync_err,
  output logic                     overrun,
  input  logic                     clr_err
);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;
  typedef logic [NLINES-1:0][WIDTH-1:0] words_t;

  // 7-bit slot bounds so OFFSET+WIDTH+31 never wraps the 6-bit position.
  localparam logic [6:0] LLast  = 7'(OFFSET + WIDTH - 1);
  localparam logic [6:0] RLast  = 7'(OFFSET + WIDTH + 31);
  localparam logic [6:0] LFirst = 7'(OFFSET);
  localparam logic [6:0] RFirst = 7'(OFFSET + 32);
  localparam logic [6:0] WLen   = 7'(WIDTH);

  state_e     state_q, state_d;
  logic [5:0] exp_q, exp_d;
  words_t     lshift_q, lshift_d;
  words_t     rshift_q, rshift_d;
  words_t     pend_q, pend_d;
  words_t     left_q, left_d;
  words_t     right_q, right_d;
  logic       valid_q, valid_d;
  logic       sync_err_q, sync_err_d;
  logic       overrun_q, overrun_d;

  logic [6:0] posn7, l_off, r_off;
  logic       in_l, in_r, mismatch, proc;
  words_t     lnext, rnext;

  assign posn7    = {1'b0, frame_posn};
  assign l_off    = posn7 - LFirst;
  assign r_off    = posn7 - RFirst;
  // Out-of-range positions wrap to large offsets, so one compare covers both bounds.
  assign in_l     = l_off < WLen;
  assign in_r     = r_off < WLen;
  assign mismatch = (state_q == StLocked) && (frame_posn != exp_q);
  assign proc     = ((state_q == StLocked) && (frame_posn == exp_q)) || (frame_posn == 6'd0);

  // A broken frame restarts from an empty word, so the new bit shifts into zeros.
  for (genvar k = 0; k < NLINES; k++) begin : g_shift
    if (WIDTH == 1) begin : g_w1
      assign lnext[k] = sd[k];
      assign rnext[k] = sd[k];
    end else begin : g_wn
      assign lnext[k] = mismatch ? {{(WIDTH-1){1'b0}}, sd[k]} : {lshift_q[k][WIDTH-2:0], sd[k]};
      assign rnext[k] = mismatch ? {{(WIDTH-1){1'b0}}, sd[k]} : {rshift_q[k][WIDTH-2:0], sd[k]};
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    pend_d     = pend_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    sync_err_d = sync_err_q;
    overrun_d  = overrun_q;

    if (valid_q && out_ready) valid_d = 1'b0;
    if (clr_err) begin
      sync_err_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (sample) begin
      exp_d = frame_posn + 6'd1;
      if (mismatch) begin
        sync_err_d = 1'b1;
        lshift_d   = '0;
        rshift_d   = '0;
        pend_d     = '0;
      end
      if (state_q == StUnlocked && frame_posn == 6'd0) begin
        state_d = StLocked;
      end else if (mismatch && frame_posn != 6'd0) begin
        state_d = StUnlocked;
      end

      if (proc) begin
        if (in_l) begin
          lshift_d = lnext;
          if (posn7 == LLast) pend_d = lnext;
        end
        if (in_r) begin
          rshift_d = rnext;
          if (posn7 == RLast) begin
            if (!valid_q || out_ready) begin
              left_d  = pend_d;
              right_d = rnext;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StUnlocked;
      exp_q      <= '0;
      lshift_q   <= '0;
      rshift_q   <= '0;
      pend_q     <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      pend_q     <= pend_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign left      = left_q;
  assign right     = right_q;
  assign locked    = (state_q == StLocked);
  assign sync_err  = sync_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Scoreboard bench for i2s_rx_multi: a 2-line 16-bit instance and a 1-line 24-bit
// instance driven with directed frames; a monitor pops expected frames on each handshake.
module tb_i2s_rx_multi;

  localparam int NA = 2, WA = 16, OA = 1;
  localparam int NB = 1, WB = 24, OB = 0;

  logic ck = 1'b0;
  always #5 ck = ~ck;
  logic rst_n = 1'b1;

  logic              sample_a = 1'b0, ready_a = 1'b1, clr_a = 1'b0;
  logic [5:0]        posn_a = '0;
  logic [NA-1:0]     sd_a = '0;
  logic              valid_a, locked_a, serr_a, ovr_a;
  logic [NA*WA-1:0]  left_a, right_a;

  logic              sample_b = 1'b0, ready_b = 1'b1, clr_b = 1'b0;
  logic [5:0]        posn_b = '0;
  logic [NB-1:0]     sd_b = '0;
  logic              valid_b, locked_b, serr_b, ovr_b;
  logic [NB*WB-1:0]  left_b, right_b;

  i2s_rx_multi #(.NLINES(NA), .WIDTH(WA), .OFFSET(OA)) dut_a (
    .ck(ck), .rst_n(rst_n), .sample(sample_a), .frame_posn(posn_a), .sd(sd_a),
    .out_valid(valid_a), .out_ready(ready_a), .left(left_a), .right(right_a),
    .locked(locked_a), .sync_err(serr_a), .overrun(ovr_a), .clr_err(clr_a)
  );

  i2s_rx_multi #(.NLINES(NB), .WIDTH(WB), .OFFSET(OB)) dut_b (
    .ck(ck), .rst_n(rst_n), .sample(sample_b), .frame_posn(posn_b), .sd(sd_b),
    .out_valid(valid_b), .out_ready(ready_b), .left(left_b), .right(right_b),
    .locked(locked_b), .sync_err(serr_b), .overrun(ovr_b), .clr_err(clr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q_a[$];
  logic [47:0] q_b[$];

  logic [15:0] l0, r0, l1, r1;
  logic [23:0] lb, rb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slot bits: word bits MSB-first inside each capture window, random noise elsewhere.
  function automatic logic [1:0] bits_a(input int p);
    logic [1:0]  b;
    logic [15:0] t0, t1;
    b = 2'($urandom);
    if (p >= OA && p < OA + WA) begin
      t0 = l0 << (p - OA);
      t1 = l1 << (p - OA);
      b  = {t1[15], t0[15]};
    end else if (p >= OA + 32 && p < OA + 32 + WA) begin
      t0 = r0 << (p - OA - 32);
      t1 = r1 << (p - OA - 32);
      b  = {t1[15], t0[15]};
    end
    return b;
  endfunction

  function automatic logic bits_b(input int p);
    logic        b;
    logic [23:0] t;
    b = 1'($urandom);
    if (p < OB + WB) begin
      t = lb << (p - OB);
      b = t[23];
    end else if (p >= OB + 32 && p < OB + 32 + WB) begin
      t = rb << (p - OB - 32);
      b = t[23];
    end
    return b;
  endfunction

  task automatic idle();
    @(posedge ck);
    #1;
  endtask

  task automatic strobe_a(input int p);
    sample_a = 1'b1;
    posn_a   = 6'(p);
    sd_a     = bits_a(p);
    idle();
    sample_a = 1'b0;
  endtask

  task automatic strobe_b(input int p);
    sample_b = 1'b1;
    posn_b   = 6'(p);
    sd_b     = bits_b(p);
    idle();
    sample_b = 1'b0;
  endtask

  task automatic run_a(input int from, input int to, input int skip);
    for (int p = from; p <= to; p++) begin
      if (p != skip) begin
        strobe_a(p);
        idle();
      end
    end
  endtask

  task automatic run_b(input int from, input int to);
    for (int p = from; p <= to; p++) begin
      strobe_b(p);
      idle();
    end
  endtask

  task automatic set_a(input logic [15:0] a, b, c, d, input bit push);
    l0 = a; r0 = b; l1 = c; r1 = d;
    if (push) q_a.push_back({c, a, d, b});
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    idle();
    clr_a = 1'b0;
  endtask

  // Monitor: pops on each accepted handshake and checks held data stays put under backpressure.
  initial begin
    logic        hold_a;
    logic [63:0] held_a, e;
    hold_a = 1'b0;
    held_a = '0;
    forever begin
      @(negedge ck);
      if (!rst_n) begin
        hold_a = 1'b0;
      end else begin
        if (hold_a) chk("hold_a", {left_a, right_a}, held_a);
        if (valid_a && ready_a) begin
          if (q_a.size() == 0) chk("unexpected_valid_a", valid_a, 1'b0);
          else begin
            e = q_a.pop_front();
            chk("frame_a", {left_a, right_a}, e);
          end
        end
        if (valid_b && ready_b) begin
          if (q_b.size() == 0) chk("unexpected_valid_b", valid_b, 1'b0);
          else chk("frame_b", {16'h0, left_b, right_b}, {16'h0, q_b.pop_front()});
        end
        hold_a = valid_a && !ready_a;
        held_a = {left_a, right_a};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    idle();
    chk("rst_valid", valid_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_flags", {serr_a, ovr_a}, 0);
    chk("rst_data", {left_a, right_a}, 0);
    rst_n = 1'b1;
    idle();

    // Test 1: basic two-line frame and one-cycle latency after the last right bit.
    set_a(16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 1'b1);
    run_a(0, 47, -1);
    chk("t1_locked", locked_a, 1);
    chk("t1_valid_before", valid_a, 0);
    strobe_a(48);
    chk("t1_latency", valid_a, 1);
    idle();
    run_a(49, 63, -1);

    // Test 2: backpressure, overrun, clear, and reload on the accepting cycle.
    ready_a = 1'b0;
    set_a(16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3, 1'b1);
    run_a(0, 63, -1);
    chk("t2_held_valid", valid_a, 1);
    chk("t2_ovr_before", ovr_a, 0);
    set_a(16'hDEAD, 16'hBEEF, 16'h1111, 16'h2222, 1'b0);
    run_a(0, 63, -1);
    chk("t2_overrun", ovr_a, 1);
    chk("t2_held_data", {left_a, right_a}, 64'h3C3C0F0FC3C3F0F0);
    pulse_clr_a();
    chk("t2_ovr_clr", ovr_a, 0);
    set_a(16'h5555, 16'hAAAA, 16'h0001, 16'h8000, 1'b1);
    run_a(0, 47, -1);
    ready_a = 1'b1;
    strobe_a(48);
    chk("t2_valid_stays", valid_a, 1);
    chk("t2_reload", {left_a, right_a}, 64'h00015555_8000AAAA);
    chk("t2_no_ovr", ovr_a, 0);
    idle();
    run_a(49, 63, -1);

    // Test 3: skipped slot breaks lock; relock on next slot 0.
    set_a(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    run_a(0, 63, 20);
    chk("t3_sync_err", serr_a, 1);
    chk("t3_unlocked", locked_a, 0);
    pulse_clr_a();
    chk("t3_serr_clr", serr_a, 0);
    set_a(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 1'b1);
    run_a(0, 63, -1);
    chk("t3_relocked", locked_a, 1);

    // Test 4: early jump to slot 0 keeps lock and restarts the frame.
    set_a(16'h7777, 16'h6666, 16'h5555, 16'h4444, 1'b0);
    run_a(0, 40, -1);
    set_a(16'hFFFF, 16'h0000, 16'h4321, 16'h8765, 1'b1);
    strobe_a(0);
    chk("t4_sync_err", serr_a, 1);
    chk("t4_locked", locked_a, 1);
    idle();
    run_a(1, 63, -1);
    pulse_clr_a();

    // Test 5: start mid-frame, then asynchronous reset mid-frame.
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    idle();
    set_a(16'hCAFE, 16'hF00D, 16'hBEAD, 16'hFACE, 1'b0);
    run_a(30, 63, -1);
    chk("t5_not_locked", locked_a, 0);
    run_a(0, 40, -1);
    chk("t5_locked", locked_a, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_locked", locked_a, 0);
    chk("t5_rst_outs", {valid_a, serr_a, ovr_a}, 0);
    chk("t5_rst_data", {left_a, right_a}, 0);
    idle();
    idle();
    rst_n = 1'b1;
    run_a(41, 63, -1);
    chk("t5_still_unlocked", locked_a, 0);

    // Test 6: 24-bit words at offset 0; error set wins over a same-cycle clear.
    lb = 24'h800001;
    rb = 24'h5A5A5A;
    q_b.push_back({lb, rb});
    run_b(0, 63);
    chk("t6_serr_before", serr_b, 0);
    clr_b = 1'b1;
    strobe_b(5);
    clr_b = 1'b0;
    chk("t6_set_wins", serr_b, 1);
    chk("t6_unlocked", locked_b, 0);
    idle();

    idle();
    idle();
    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
